// File: rtl/filtro_iir_seq_pkg.sv
// rtl/filtro_iir_seq_pkg.sv - shared widths, FSM encoding and clamp limits for the IIR stage
package filtro_iir_seq_pkg;

   localparam int W     = 19;
   localparam int F     = 10;
   localparam int ACC_W = 2*W + 3;

   localparam logic [2:0] IDX_LAST = 3'd4;

   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_SAT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*W-1:0] p);
      return {{(ACC_W-2*W){p[2*W-1]}}, p};
   endfunction

   function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [W-1:0] v);
      return {{(ACC_W-W){v[W-1]}}, v};
   endfunction

endpackage

// File: rtl/filtro_iir_seq_sat_trunc.sv
// rtl/filtro_iir_seq_sat_trunc.sv - accumulator to sample conversion: floor shift by F then clamp
module sat_trunc
   import filtro_iir_seq_pkg::*;
(
   input  logic signed [ACC_W-1:0] i_acc,
   output logic signed [W-1:0]     o_sat
);

   logic signed [ACC_W-1:0] w_shift;
   logic signed [ACC_W-1:0] w_max;
   logic signed [ACC_W-1:0] w_min;

   // Arithmetic shift rounds toward minus infinity, which is the intended rounding.
   assign w_shift = i_acc >>> F;
   assign w_max   = sext_w(SAT_MAX);
   assign w_min   = sext_w(SAT_MIN);

   always_comb begin
      o_sat = w_shift[W-1:0];
      if (w_shift > w_max) begin
         o_sat = SAT_MAX;
      end else if (w_shift < w_min) begin
         o_sat = SAT_MIN;
      end
   end

endmodule

// File: rtl/filtro_iir_seq.sv
// rtl/filtro_iir_seq.sv - sequential direct-form-I biquad, one shared multiplier, 5 MAC cycles per sample
module filtro_iir_seq
   import filtro_iir_seq_pkg::*;
(
   input  logic                CLK,
   input  logic                Reset,
   input  logic                start,
   input  logic signed [W-1:0] x_in,
   input  logic signed [W-1:0] b0,
   input  logic signed [W-1:0] b1,
   input  logic signed [W-1:0] b2,
   input  logic signed [W-1:0] a1,
   input  logic signed [W-1:0] a2,
   output logic signed [W-1:0] y_out,
   output logic                busy,
   output logic                done
);

   state_t                  r_state;
   logic [2:0]              r_idx;
   logic signed [ACC_W-1:0] r_acc;

   logic signed [W-1:0] r_x;
   logic signed [W-1:0] r_x1;
   logic signed [W-1:0] r_x2;
   logic signed [W-1:0] r_y1;
   logic signed [W-1:0] r_y2;

   logic signed [W-1:0] r_b0;
   logic signed [W-1:0] r_b1;
   logic signed [W-1:0] r_b2;
   logic signed [W-1:0] r_a1;
   logic signed [W-1:0] r_a2;

   logic signed [W-1:0] r_y_out;
   logic                r_busy;
   logic                r_done;

   logic signed [W-1:0]     w_coef;
   logic signed [W-1:0]     w_samp;
   logic                    w_sub;
   logic signed [2*W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_term;
   logic signed [ACC_W-1:0] w_acc_next;
   logic signed [W-1:0]     w_sat;

   // Operand select: feed-forward terms are added, feedback terms subtracted.
   always_comb begin
      w_coef = '0;
      w_samp = '0;
      w_sub  = 1'b0;
      case (r_idx)
         3'd0: begin
            w_coef = r_b0;
            w_samp = r_x;
         end
         3'd1: begin
            w_coef = r_b1;
            w_samp = r_x1;
         end
         3'd2: begin
            w_coef = r_b2;
            w_samp = r_x2;
         end
         3'd3: begin
            w_coef = r_a1;
            w_samp = r_y1;
            w_sub  = 1'b1;
         end
         3'd4: begin
            w_coef = r_a2;
            w_samp = r_y2;
            w_sub  = 1'b1;
         end
         default: begin
            w_coef = '0;
            w_samp = '0;
            w_sub  = 1'b0;
         end
      endcase
   end

   assign w_prod     = w_coef * w_samp;
   assign w_term     = sext_prod(w_prod);
   assign w_acc_next = w_sub ? (r_acc - w_term) : (r_acc + w_term);

   sat_trunc u_sat_trunc (
      .i_acc (r_acc),
      .o_sat (w_sat)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_acc   <= '0;
         r_x     <= '0;
         r_x1    <= '0;
         r_x2    <= '0;
         r_y1    <= '0;
         r_y2    <= '0;
         r_b0    <= '0;
         r_b1    <= '0;
         r_b2    <= '0;
         r_a1    <= '0;
         r_a2    <= '0;
         r_y_out <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_x     <= x_in;
                  r_b0    <= b0;
                  r_b1    <= b1;
                  r_b2    <= b2;
                  r_a1    <= a1;
                  r_a2    <= a2;
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_MAC;
               end
            end
            ST_MAC: begin
               r_acc <= w_acc_next;
               if (r_idx == IDX_LAST) begin
                  r_state <= ST_SAT;
               end else begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            ST_SAT: begin
               // The clamped value, not the raw accumulator, feeds the recursion.
               r_y_out <= w_sat;
               r_x2    <= r_x1;
               r_x1    <= r_x;
               r_y2    <= r_y1;
               r_y1    <= w_sat;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign y_out = r_y_out;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_filtro_iir_seq.sv
// tb/tb_filtro_iir_seq.sv - randomized and directed checks of filtro_iir_seq against an arithmetic model
module tb_filtro_iir_seq;

   logic               clk;
   logic               rst;
   logic               start;
   logic signed [18:0] x_in, b0, b1, b2, a1, a2;
   logic signed [18:0] y_out;
   logic               busy;
   logic               done;

   int n_checks = 0;
   int n_errors = 0;

   longint m_x1, m_x2, m_y1, m_y2;

   filtro_iir_seq dut (
      .CLK   (clk),
      .Reset (rst),
      .start (start),
      .x_in  (x_in),
      .b0    (b0),
      .b1    (b1),
      .b2    (b2),
      .a1    (a1),
      .a2    (a2),
      .y_out (y_out),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
   endfunction

   function automatic longint model_step(input longint x, input longint c0, input longint c1,
                                         input longint c2, input longint d1, input longint d2);
      longint acc, y;
      acc = c0*x + c1*m_x1 + c2*m_x2 - d1*m_y1 - d2*m_y2;
      y = acc >>> 10;
      if (y > 262143) y = 262143;
      if (y < -262144) y = -262144;
      m_x2 = m_x1; m_x1 = x;
      m_y2 = m_y1; m_y1 = y;
      return y;
   endfunction

   function automatic logic signed [18:0] rnd19();
      logic [31:0] r;
      r = $urandom;
      return r[18:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_sample(input string tag, input longint x, input longint c0, input longint c1,
                             input longint c2, input longint d1, input longint d2);
      longint exp;
      int n;
      exp = model_step(x, c0, c1, c2, d1, d2);
      @(negedge clk);
      x_in = x[18:0]; b0 = c0[18:0]; b1 = c1[18:0]; b2 = c2[18:0]; a1 = d1[18:0]; a2 = d2[18:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_on"}, longint'(busy), 1);
      // Inputs wander mid-operation; only the values latched at start may count.
      x_in = rnd19(); b0 = rnd19(); b1 = rnd19(); b2 = rnd19(); a1 = rnd19(); a2 = rnd19();
      n = 1;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, longint'(n), 7);
      check({tag, "_y"}, longint'(y_out), exp);
      tick();
      check({tag, "_busy_off"}, longint'(busy), 0);
      check({tag, "_done_off"}, longint'(done), 0);
   endtask

   initial begin
      int pulses[$];
      int dones;
      int guard;
      longint c0, c1, c2, d1, d2;
      rst = 1'b1; start = 1'b0;
      x_in = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
      model_reset();
      tick(); tick();
      rst = 1'b0;
      check("rst_y", longint'(y_out), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);

      run_sample("pass", 100, 1024, 0, 0, 0, 0);

      do_reset();
      run_sample("dly0", 5, 0, 1024, 0, 0, 0);
      run_sample("dly1", 0, 0, 1024, 0, 0, 0);
      run_sample("dly2", 0, 0, 1024, 0, 0, 0);

      do_reset();
      run_sample("fb0", 1000, 1024, 0, 0, -512, 0);
      for (int i = 1; i < 5; i++) run_sample("fbn", 0, 1024, 0, 0, -512, 0);
      check("fb_final", longint'(y_out), 62);

      do_reset();
      run_sample("floor_neg", -3, 512, 0, 0, 0, 0);
      check("floor_neg_abs", longint'(y_out), -2);
      run_sample("floor_pos", 3, 512, 0, 0, 0, 0);

      do_reset();
      run_sample("sat_hi", 200000, 2048, 0, 0, 0, 0);
      check("sat_hi_abs", longint'(y_out), 262143);
      run_sample("sat_lo", -200000, 2048, 0, 0, 0, 0);
      check("sat_lo_abs", longint'(y_out), -262144);
      run_sample("sat_zero", 0, 2048, 0, 0, 0, 0);

      // Start held high: one accepted sample every 8 cycles.
      do_reset();
      @(negedge clk);
      x_in = 19'sd123; b0 = 19'sd1024; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (done) pulses.push_back(c);
      end
      start = 1'b0;
      guard = 0;
      while (busy && guard < 20) begin
         tick();
         guard++;
      end
      check("hold_idle", longint'(busy), 0);
      check("hold_count", longint'(pulses.size()), 5);
      if (pulses.size() > 0) check("hold_first", longint'(pulses[0]), 7);
      for (int i = 1; i < pulses.size(); i++)
         check("hold_period", longint'(pulses[i] - pulses[i-1]), 8);
      check("hold_y", longint'(y_out), 123);

      // Reset in the middle of MAC aborts without done and clears history.
      do_reset();
      run_sample("pre_abort", 50, 1024, 0, 0, 0, 0);
      @(negedge clk);
      x_in = 19'sd77; b0 = 19'sd1024; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check("abort_y", longint'(y_out), 0);
      check("abort_busy", longint'(busy), 0);
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) dones++;
         tick();
      end
      check("abort_nodone", longint'(dones), 0);
      run_sample("post_abort", 7, 1024, 1024, 0, 0, 0);
      check("post_abort_abs", longint'(y_out), 7);

      // Random stimulus against the model.
      do_reset();
      for (int i = 0; i < 60; i++) begin
         if (i % 10 == 9) begin
            c0 = longint'(rnd19()); c1 = longint'(rnd19()); c2 = longint'(rnd19());
            d1 = longint'(rnd19()); d2 = longint'(rnd19());
         end else begin
            c0 = longint'($urandom_range(2048)) - 1024;
            c1 = longint'($urandom_range(2048)) - 1024;
            c2 = longint'($urandom_range(1024)) - 512;
            d1 = longint'($urandom_range(1024)) - 512;
            d2 = longint'($urandom_range(512)) - 256;
         end
         run_sample("rnd", longint'(rnd19()), c0, c1, c2, d1, d2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
